pipelined_addsub: RTL

- Parametrised, pipelined WIDTH-bit adder/subtractor.
- Successor to the single-bit registered adder cells. Splits the operand into STAGES chunks and propagates the carry chunk-by-chunk through registered stages.
- Valid/ready handshake on both sides, so it drops into streaming datapaths.
- Provides carry-in/borrow-in, carry-out and signed overflow.

---
 rtl/addsub_pkg.sv | 12 +
 rtl/addsub_stage.sv | 42 ++++
 rtl/pipelined_addsub.sv | 131 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked pipelined adder/subtractor.
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/addsub_stage.sv
// One chunk of the carry pipeline: CHUNK-bit add of two operand slices plus
// the incoming carry, registered together with the beat's valid bit.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  stage_ctl_t       ctl_i,
  output logic [CHUNK-1:0] sum_o,
  output stage_ctl_t       ctl_o
);

  logic [CHUNK:0]   total_d;
  logic [CHUNK-1:0] sum_q;
  stage_ctl_t       ctl_q;

  // Chunk sum with carry-out in the top bit
  always_comb begin
    total_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ctl_i.carry};
  end

  // Stage registers advance only with the global pipeline enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
      ctl_q <= '0;
    end else if (en_i) begin
      sum_q       <= total_d[CHUNK-1:0];
      ctl_q.carry <= total_d[CHUNK];
      ctl_q.valid <= ctl_i.valid;
    end
  end

  assign sum_o = sum_q;
  assign ctl_o = ctl_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry ripples one CHUNK per stage,
// operands are skewed in and completed result chunks deskewed out.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             adv_s;
  logic [WIDTH-1:0] b_eff_s;
  stage_ctl_t       ctl0_s;
  stage_ctl_t       ctl_s     [STAGES];
  logic [CHUNK-1:0] a_sk_s    [STAGES];
  logic [CHUNK-1:0] b_sk_s    [STAGES];
  logic [CHUNK-1:0] stg_sum_s [STAGES];
  logic [CHUNK-1:0] res_s     [STAGES];
  logic             ab_msb_q;

  assign adv_s    = out_ready | ~out_valid;
  assign in_ready = adv_s;

  // Subtraction is a + ~b + ~cin, so the mode is folded in before skewing
  assign b_eff_s      = (sub == SUB) ? ~b : b;
  assign ctl0_s.valid = in_valid;
  assign ctl0_s.carry = (sub == SUB) ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_ctl_t ctl_in_s;

    if (k == 0) begin : g_first
      assign a_sk_s[k] = a[CHUNK-1:0];
      assign b_sk_s[k] = b_eff_s[CHUNK-1:0];
      assign ctl_in_s  = ctl0_s;
    end else begin : g_skew
      logic [CHUNK-1:0] a_dl_q [k];
      logic [CHUNK-1:0] b_dl_q [k];

      // Operand chunk k waits k cycles to meet its carry
      always_ff @(posedge clk) begin
        if (adv_s) begin
          a_dl_q[0] <= a[k*CHUNK +: CHUNK];
          b_dl_q[0] <= b_eff_s[k*CHUNK +: CHUNK];
          for (int j = 1; j < k; j++) begin
            a_dl_q[j] <= a_dl_q[j-1];
            b_dl_q[j] <= b_dl_q[j-1];
          end
        end
      end

      assign a_sk_s[k] = a_dl_q[k-1];
      assign b_sk_s[k] = b_dl_q[k-1];
      assign ctl_in_s  = ctl_s[k-1];
    end

    addsub_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk_i (clk),
      .rst_ni(rst),
      .en_i  (adv_s),
      .a_i   (a_sk_s[k]),
      .b_i   (b_sk_s[k]),
      .ctl_i (ctl_in_s),
      .sum_o (stg_sum_s[k]),
      .ctl_o (ctl_s[k])
    );

    if (k < STAGES - 1) begin : g_deskew
      localparam int DEPTH = STAGES - 1 - k;
      logic [CHUNK-1:0] dsk_q [DEPTH];

      // Finished low chunk rides along until the top chunk completes
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int j = 0; j < DEPTH; j++) begin
            dsk_q[j] <= '0;
          end
        end else if (adv_s) begin
          dsk_q[0] <= stg_sum_s[k];
          for (int j = 1; j < DEPTH; j++) begin
            dsk_q[j] <= dsk_q[j-1];
          end
        end
      end

      assign res_s[k] = dsk_q[DEPTH-1];
    end else begin : g_last
      assign res_s[k] = stg_sum_s[k];
    end
  end

  // Sign bits entering the last stage, kept to recover the carry into the MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ab_msb_q <= 1'b0;
    end else if (adv_s) begin
      ab_msb_q <= a_sk_s[STAGES-1][CHUNK-1] ^ b_sk_s[STAGES-1][CHUNK-1];
    end
  end

  // Reassemble the result from the aligned chunks
  always_comb begin
    sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum[k*CHUNK +: CHUNK] = res_s[k];
    end
  end

  assign out_valid = ctl_s[STAGES-1].valid;
  assign cout      = ctl_s[STAGES-1].carry;
  // carry into MSB = a^b^sum at the MSB; overflow when it differs from carry out
  assign ovf       = ab_msb_q ^ sum[WIDTH-1] ^ cout;

endmodule
